// File: rtl/extensor_pkg.sv
// Shared mode codes and pipe state encoding for the immediate extender.
// State bits are {skid occupied, out occupied}.
package extensor_pkg;

  localparam int MODO_W = 3;

  typedef logic [MODO_W-1:0] modo_t;

  localparam modo_t MODO_SEXT_A   = 3'd0;
  localparam modo_t MODO_SEXT_B   = 3'd1;
  localparam modo_t MODO_ZEXT_A   = 3'd2;
  localparam modo_t MODO_UPPER_A  = 3'd3;
  localparam modo_t MODO_BRANCH_B = 3'd4;

  // bit0 = OUT occupied, bit1 = SKID occupied; 2'b10 is unreachable
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } pipe_state_e;

endpackage

// File: rtl/extensor_calc.sv
// Combinational immediate extension: picks sign/zero/upper/branch form by mode
// and flags the unassigned mode codes, which yield an all-zero result.
module extensor_calc
  import extensor_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int IMM_A_W = 16,
  parameter int IMM_B_W = 21
) (
  input  logic [IMM_A_W-1:0] in16,
  input  logic [IMM_B_W-1:0] in21,
  input  modo_t              modo,
  output logic [DATA_W-1:0]  valor,
  output logic               ilegal
);

  logic signed [IMM_A_W-1:0] a_s;
  logic signed [IMM_B_W-1:0] b_s;
  logic signed [IMM_B_W+1:0] br_s;

  assign a_s  = $signed(in16);
  assign b_s  = $signed(in21);
  assign br_s = $signed({in21, 2'b00});

  always_comb begin
    valor  = '0;
    ilegal = 1'b0;
    case (modo)
      MODO_SEXT_A:   valor = DATA_W'(a_s);
      MODO_SEXT_B:   valor = DATA_W'(b_s);
      MODO_ZEXT_A:   valor = DATA_W'(in16);
      MODO_UPPER_A:  valor = DATA_W'(in16) << (DATA_W - IMM_A_W);
      MODO_BRANCH_B: valor = DATA_W'(br_s);
      default:       ilegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/extensor_pipe.sv
// Pipelined immediate extender: output register plus one-entry skid buffer
// with valid/ready on both sides and a sticky illegal-mode flag.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   ST_EMPTY | no result held, in_ready high
//   ST_ONE   | OUT holds a result, SKID free
//   ST_FULL  | OUT and SKID both hold results, in_ready low
module extensor_pipe
  import extensor_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int IMM_A_W = 16,
  parameter int IMM_B_W = 21
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IMM_A_W-1:0] in16,
  input  logic [IMM_B_W-1:0] in21,
  input  modo_t              modo,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  extendido,
  output logic               erro_modo,
  input  logic               limpa_erro
);

  pipe_state_e       state_q, state_d;
  logic [DATA_W-1:0] out_q, skid_q, calc_valor;
  logic              calc_ilegal;
  logic              in_ready_q, erro_q;
  logic              accept, transfer;
  logic              load_out_new, load_out_skid, load_skid;

  extensor_calc #(
    .DATA_W  (DATA_W),
    .IMM_A_W (IMM_A_W),
    .IMM_B_W (IMM_B_W)
  ) u_calc (
    .in16   (in16),
    .in21   (in21),
    .modo   (modo),
    .valor  (calc_valor),
    .ilegal (calc_ilegal)
  );

  assign accept   = in_valid && in_ready_q;
  assign transfer = state_q[0] && out_ready;

  always_comb begin
    state_d       = state_q;
    load_out_new  = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d      = ST_ONE;
          load_out_new = 1'b1;
        end
      end
      ST_ONE: begin
        if (transfer && accept) begin
          load_out_new = 1'b1;
        end else if (transfer) begin
          state_d = ST_EMPTY;
        end else if (accept) begin
          state_d   = ST_FULL;
          load_skid = 1'b1;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only a drain into OUT can happen
        if (transfer) begin
          state_d       = ST_ONE;
          load_out_skid = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
      out_q      <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_FULL);
      if (load_out_new) begin
        out_q <= calc_valor;
      end else if (load_out_skid) begin
        out_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= calc_valor;
      end
    end
  end

  // a new illegal accept outranks a simultaneous clear
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      erro_q <= 1'b0;
    end else if (accept && calc_ilegal) begin
      erro_q <= 1'b1;
    end else if (limpa_erro) begin
      erro_q <= 1'b0;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = state_q[0];
  assign extendido = state_q[0] ? out_q : '0;
  assign erro_modo = erro_q;

endmodule
